// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle ARM datapath.
// Holds the main multicycle FSM, the NZCV flag register and the
// conditional-execution logic. It decodes Instr and drives every datapath
// control input plus the memory write enable.
module mc_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  StateDbg
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;

  logic [3:0] flags;
  logic       cond_ex;
  logic       cond_ex_reg;

  logic [1:0] alu_dec;
  logic       alu_valid;
  logic       alu_arith;
  logic       in_exec;
  logic       flag_write;

  // Instruction fields outside cond/op/funct are consumed by the datapath only.
  logic       unused_instr_bits;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];

  assign unused_instr_bits = ^Instr[19:0];

  assign in_exec    = (state == EXECR) || (state == EXECI);
  assign flag_write = in_exec && cond_ex_reg && funct[0] && alu_valid;

  assign StateDbg = state;
  assign ImmSrc   = op;
  // Branches read R15 on RA1; stores read Rd on RA2 so it can be written to memory.
  assign RegSrc   = {(op == 2'b01) && !funct[0], (op == 2'b10)};

  // Data-processing command decode; unsupported commands are flagged invalid.
  always_comb begin
    alu_dec   = 2'b00;
    alu_valid = 1'b1;
    alu_arith = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = 2'b00; alu_arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; alu_arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_valid = 1'b0;
    endcase
  end

  // Condition check against the registered NZCV flags.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !(c && !z);
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = !(!z && (n == v));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // FSM state register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Condition latch in DECODE and flag updates at the end of an execute state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_ex_reg <= 1'b0;
      flags       <= FLAGS_RST;
    end else begin
      if (state == DECODE) cond_ex_reg <= cond_ex;
      if (flag_write) begin
        flags[3:2] <= ALUFlags[3:2];
        if (alu_arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state logic and Moore control outputs.
  always_comb begin
    state_next = FETCH;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b00:   state_next = funct[5] ? EXECI : EXECR;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = cond_ex_reg;
        state_next = FETCH;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        MemWrite   = cond_ex_reg;
        state_next = FETCH;
      end
      EXECR: begin
        ALUControl = alu_dec;
        state_next = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = cond_ex_reg && alu_valid;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex_reg;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule
